// File: rtl/mem_stage.sv
// Memory pipeline stage: passes ALU results to writeback and performs byte/word
// loads and stores against a variable-latency req/ack data memory.
module mem_stage #(
   parameter int ADDR_W  = 20,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic [6:0]        exec_op,
   input  logic [DATA_W-1:0] exec_result,
   input  logic [4:0]        exec_dst,
   input  logic [ADDR_W-1:0] exec_addr,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [3:0]        mem_wstrb,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              stall,
   output logic              wb_we,
   output logic [4:0]        wb_dst,
   output logic [DATA_W-1:0] wb_data,
   output logic              mem_err
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   localparam logic [6:0] OP_ADD = 7'h00;
   localparam logic [6:0] OP_SUB = 7'h01;
   localparam logic [6:0] OP_MUL = 7'h02;
   localparam logic [6:0] OP_LDB = 7'h10;
   localparam logic [6:0] OP_LDW = 7'h11;
   localparam logic [6:0] OP_STB = 7'h12;
   localparam logic [6:0] OP_STW = 7'h13;

   typedef enum logic [0:0] {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [6:0]          op_q, op_d;
   logic [4:0]          dst_q, dst_d;
   logic                mem_req_q, mem_req_d;
   logic                mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic [3:0]          mem_wstrb_q, mem_wstrb_d;
   logic                wb_we_q, wb_we_d;
   logic [4:0]          wb_dst_q, wb_dst_d;
   logic [DATA_W-1:0]   wb_data_q, wb_data_d;
   logic                mem_err_q, mem_err_d;

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         op_q        <= 7'h00;
         dst_q       <= 5'd0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_wstrb_q <= 4'b0000;
         wb_we_q     <= 1'b0;
         wb_dst_q    <= 5'd0;
         wb_data_q   <= '0;
         mem_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         op_q        <= op_d;
         dst_q       <= dst_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_wstrb_q <= mem_wstrb_d;
         wb_we_q     <= wb_we_d;
         wb_dst_q    <= wb_dst_d;
         wb_data_q   <= wb_data_d;
         mem_err_q   <= mem_err_d;
      end
   end

   // Next-state and registered-output logic
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      op_d        = op_q;
      dst_d       = dst_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_wstrb_d = mem_wstrb_q;
      wb_we_d     = 1'b0;
      wb_dst_d    = wb_dst_q;
      wb_data_d   = wb_data_q;
      mem_err_d   = mem_err_q;

      case (state_q)
         S_IDLE: begin
            if (enable) begin
               case (exec_op)
                  OP_ADD, OP_SUB, OP_MUL: begin
                     wb_we_d   = 1'b1;
                     wb_data_d = exec_result;
                     wb_dst_d  = exec_dst;
                  end
                  OP_LDB, OP_LDW: begin
                     state_d     = S_WAIT;
                     cnt_d       = '0;
                     op_d        = exec_op;
                     dst_d       = exec_dst;
                     mem_req_d   = 1'b1;
                     mem_we_d    = 1'b0;
                     mem_addr_d  = exec_addr;
                     mem_wdata_d = '0;
                     mem_wstrb_d = 4'b0000;
                  end
                  OP_STB, OP_STW: begin
                     state_d    = S_WAIT;
                     cnt_d      = '0;
                     op_d       = exec_op;
                     dst_d      = exec_dst;
                     mem_req_d  = 1'b1;
                     mem_we_d   = 1'b1;
                     mem_addr_d = exec_addr;
                     if (exec_op == OP_STB) begin
                        mem_wdata_d = {{(DATA_W-8){1'b0}}, exec_result[7:0]};
                        mem_wstrb_d = 4'b0001;
                     end else begin
                        mem_wdata_d = exec_result;
                        mem_wstrb_d = 4'b1111;
                     end
                  end
                  default: begin
                     wb_we_d = 1'b0;
                  end
               endcase
            end else begin
               wb_we_d = 1'b0;
            end
         end
         S_WAIT: begin
            // An ack on the final allowed cycle still completes the access.
            if (mem_ack) begin
               state_d     = S_IDLE;
               mem_req_d   = 1'b0;
               mem_we_d    = 1'b0;
               mem_wstrb_d = 4'b0000;
               if (op_q == OP_LDW) begin
                  wb_we_d   = 1'b1;
                  wb_dst_d  = dst_q;
                  wb_data_d = mem_rdata;
               end else if (op_q == OP_LDB) begin
                  wb_we_d   = 1'b1;
                  wb_dst_d  = dst_q;
                  wb_data_d = {{(DATA_W-8){1'b0}}, mem_rdata[7:0]};
               end else begin
                  wb_we_d = 1'b0;
               end
            end else if (cnt_q == CNT_LAST) begin
               state_d     = S_IDLE;
               mem_req_d   = 1'b0;
               mem_we_d    = 1'b0;
               mem_wstrb_d = 4'b0000;
               mem_err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign stall     = (state_q == S_WAIT);
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_wstrb = mem_wstrb_q;
   assign wb_we     = wb_we_q;
   assign wb_dst    = wb_dst_q;
   assign wb_data   = wb_data_q;
   assign mem_err   = mem_err_q;

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Fourth pipeline stage; sits between the Execution stage and register-file writeback.
- Consumes the execute result, destination register, memory opcode and 20-bit word address.
- Performs LDB/LDW/STB/STW against a variable-latency data memory using a req/ack handshake.
- Stalls the upstream pipeline while a memory access is in flight and passes ALU results through to writeback.

Parameters:
ADDR_W, 20, word-address width (2^20 x 32-bit memory)
DATA_W, 32, data width
TIMEOUT, 15, max cycles waiting for mem_ack before abort

Ports:
clk  input  1  pipeline clock, rising edge
rst_n  input  1  asynchronous active-low reset
enable  input  1  stage enable from pipeline control
exec_op  input  7  opcode from Execution (00 add, 01 sub, 02 mult, 10 LDB, 11 LDW, 12 STB, 13 STW, 3F nop)
exec_result  input  32  ALU result, or store data for STB/STW
exec_dst  input  5  destination register
exec_addr  input  ADDR_W  memory word address
mem_req  output  1  memory request, held until ack
mem_we  output  1  1 = write, 0 = read
mem_addr  output  ADDR_W  memory word address
mem_wdata  output  32  write data
mem_wstrb  output  4  byte-lane write strobes
mem_rdata  input  32  read data, valid when mem_ack=1
mem_ack  input  1  one-cycle completion pulse
stall  output  1  high while an access is in flight; upstream holds
wb_we  output  1  register-file write enable, one-cycle pulse
wb_dst  output  5  writeback register
wb_data  output  32  writeback data
mem_err  output  1  sticky timeout flag

Behaviour:
- Reset (async, rst_n=0): all outputs 0, FSM=IDLE, timeout counter=0. Takes effect immediately, including mid-transaction; mem_req drops at once.
- FSM states: IDLE, WAIT.
- stall = (state==WAIT), combinational from the state register.
- IDLE, enable=1, exec_op in {00,01,02}: next edge wb_we=1, wb_data=exec_result, wb_dst=exec_dst.
- IDLE, exec_op=3F, unknown op, or enable=0: wb_we=0, no memory activity.
- IDLE, enable=1, exec_op in {10..13}: on the edge, capture op, dst and addr; drive mem_addr=exec_addr and mem_req=1; go to WAIT; counter=0; wb_we=0.
- Loads (10, 11): mem_we=0, mem_wstrb=0000.
- STW (13): mem_we=1, mem_wdata=exec_result, mem_wstrb=1111.
- STB (12): mem_we=1, mem_wdata={24'h0, exec_result[7:0]}, mem_wstrb=0001.
- WAIT: mem_req, mem_we, mem_addr, mem_wdata and mem_wstrb are held stable. Counter increments each cycle without ack.
- WAIT, mem_ack=1: next edge mem_req=0 and go to IDLE.
  - LDW: wb_we=1, wb_data=mem_rdata.
  - LDB: wb_we=1, wb_data={24'h0, mem_rdata[7:0]} (zero-extended).
  - Stores: wb_we=0.
- WAIT, counter reaches TIMEOUT-1 with no ack: next edge mem_req=0, mem_err=1, wb_we=0, go to IDLE. A later ack is ignored.
- mem_err stays 1 until reset.
- mem_ack in IDLE is ignored.
- Ack and timeout on the same cycle: ack wins; no error.
- enable and exec_* are ignored in WAIT; upstream holds them stable while stall=1. enable=0 in WAIT does not abort the access.
- Back-to-back memory ops: the second op is accepted on the first IDLE cycle after completion. Minimum occupancy is 2 cycles per memory access (ack on the first WAIT cycle).
- wb_* outputs are registered. wb_we is a single-cycle pulse per completed instruction.

Test Plan:
- ALU pass-through: exec_op=00, exec_result=32'h0000_0007, dst=5 -> next cycle wb_we=1, wb_data=7, wb_dst=5, stall=0, mem_req never asserted.
- LDW with 3-cycle latency: exec_op=11, addr=20'h00ABC; ack on the 3rd WAIT cycle with rdata=32'hDEADBEEF -> mem_req high for 3 cycles, stall high for 3 cycles, then wb_data=DEADBEEF, wb_dst correct.
- LDB zero-extend: rdata=32'h1234_56F0 -> wb_data=32'h0000_00F0.
- STB/STW: STB with exec_result=32'hAABBCCDD -> mem_wdata=32'h0000_00DD, wstrb=0001, we=1; STW -> wdata=AABBCCDD, wstrb=1111; wb_we=0 in both cases.
- Timeout: no ack for 15 cycles -> mem_req falls, mem_err=1 (sticky), stall=0. A late ack has no effect. A subsequent LDW with ack completes normally and mem_err stays 1.
- Reset mid-WAIT: drop rst_n on the 2nd WAIT cycle -> mem_req, stall and wb_we go to 0 immediately. An ack after rst_n release produces no writeback.
